ram_burst_master: RTL

Bus-side initiator for the 16x32 word RAM: accepts burst read/write commands from the CPU datapath over valid/ready handshakes and drives the RAM's `RW`/`address`/`data_input` port while sampling its `data_output`. It converts a single command (base address, length, direction) into a sequence of single-word RAM accesses with incrementing word addresses. Write data arrives on a streaming input; read data leaves on a back-pressured streaming output. A one-cycle `done` pulse marks burst completion.

---
 rtl/ram_burst_master_if.sv | 38 +++
 rtl/ram_burst_master.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ram_burst_master_if.sv
// Command, write-stream, read-stream and RAM-port signals of the burst master.
// The master modport is the burst master's own view; slave is the CPU/RAM side.
interface ram_burst_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 5
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  done;
    logic                  ram_rw;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_input;
    logic [DATA_WIDTH-1:0] ram_data_output;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, ram_data_output,
        output cmd_ready, wr_ready, rd_valid, rd_data, done,
        output ram_rw, ram_address, ram_data_input
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, ram_data_output,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done,
        input  ram_rw, ram_address, ram_data_input
    );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for the 16x32 word RAM: turns one burst command into a run of
// single-word RAM accesses at incrementing word addresses.
module ram_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_burst_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, WR_BEAT, RD_ISSUE, RD_WAIT, RD_HOLD, DONE} state_t;

    localparam logic [LEN_WIDTH-1:0]  MAX_LEN  = LEN_WIDTH'(16);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic                  ram_rw_q, ram_rw_d;
    logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0] ram_data_input_q, ram_data_input_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  done_q, done_d;
    logic                  last_beat;

    assign last_beat = ((count_q + LEN_ONE) == len_q);

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        len_d            = len_q;
        count_d          = count_q;
        ram_rw_d         = 1'b0;
        ram_address_d    = ram_address_q;
        ram_data_input_d = ram_data_input_q;
        rd_valid_d       = rd_valid_q;
        rd_data_d        = rd_data_q;
        // done is registered off the DONE state so it lands after the final RAM write cycle
        done_d           = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    len_d   = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;
                    count_d = '0;
                    if (bus.cmd_len == '0) begin
                        state_d = DONE;
                    end else if (bus.cmd_write) begin
                        state_d = WR_BEAT;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR_BEAT: begin
                if (bus.wr_valid) begin
                    ram_rw_d         = 1'b1;
                    ram_address_d    = addr_q;
                    ram_data_input_d = bus.wr_data;
                    addr_d           = addr_q + ADDR_ONE;
                    count_d          = count_q + LEN_ONE;
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end
            RD_ISSUE: begin
                ram_address_d = addr_q;
                state_d       = RD_WAIT;
            end
            RD_WAIT: begin
                rd_data_d  = bus.ram_data_output;
                rd_valid_d = 1'b1;
                state_d    = RD_HOLD;
            end
            RD_HOLD: begin
                if (bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    addr_d     = addr_q + ADDR_ONE;
                    count_d    = count_q + LEN_ONE;
                    state_d    = last_beat ? DONE : RD_ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            len_q            <= '0;
            count_q          <= '0;
            ram_rw_q         <= 1'b0;
            ram_address_q    <= '0;
            ram_data_input_q <= '0;
            rd_valid_q       <= 1'b0;
            rd_data_q        <= '0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            len_q            <= len_d;
            count_q          <= count_d;
            ram_rw_q         <= ram_rw_d;
            ram_address_q    <= ram_address_d;
            ram_data_input_q <= ram_data_input_d;
            rd_valid_q       <= rd_valid_d;
            rd_data_q        <= rd_data_d;
            done_q           <= done_d;
        end
    end

    assign bus.cmd_ready      = (state_q == IDLE);
    assign bus.wr_ready       = (state_q == WR_BEAT);
    assign bus.rd_valid       = rd_valid_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.done           = done_q;
    assign bus.ram_rw         = ram_rw_q;
    assign bus.ram_address    = ram_address_q;
    assign bus.ram_data_input = ram_data_input_q;
endmodule
